// File: rtl/math_pkg.sv
// rtl/math_pkg.sv - shared widths, constants and state types for the divider slice
package math_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FBITS = 16;

  localparam logic [DEF_WIDTH-1:0] SMALLEST = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  typedef enum logic [1:0] {D_IDLE, D_CALC, D_SIGN, D_FIN} div_state_t;

endpackage

// File: rtl/div.sv
// rtl/div.sv - sequential signed fixed-point restoring divider with dbz/overflow flags
module div
  import math_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FBITS = DEF_FBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             ovf,
  output logic [WIDTH-1:0] val
);

  localparam int ITER = WIDTH - 1 + FBITS;
  localparam int CW   = $clog2(ITER);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       st;
  logic [ITER-1:0]  dvd;
  logic [WIDTH-2:0] dsr;
  logic [WIDTH-2:0] rem;
  logic [WIDTH-2:0] quo;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic             ovf_acc;

  logic [WIDTH-1:0] trial;
  logic             ge;
  logic [WIDTH-2:0] rem_nxt;

  // Magnitude of a non-most-negative signed value; fits in WIDTH-1 bits.
  function automatic logic [WIDTH-2:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x[WIDTH-2:0] + (WIDTH-1)'(1)) : x[WIDTH-2:0];
  endfunction

  // One restoring step: shift in the next dividend bit and try to subtract.
  always_comb begin
    trial   = {rem, dvd[ITER-1]};
    ge      = trial[WIDTH-1] | (trial[WIDTH-2:0] >= dsr);
    rem_nxt = ge ? (trial[WIDTH-2:0] - dsr) : trial[WIDTH-2:0];
  end

  // Divider sequencer: early-out on error operands, ITER quotient bits, then sign fix-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= D_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      dbz     <= 1'b0;
      ovf     <= 1'b0;
      val     <= '0;
      dvd     <= '0;
      dsr     <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      ovf_acc <= 1'b0;
    end else begin
      case (st)
        D_IDLE: begin
          if (start) begin
            dbz  <= 1'b0;
            ovf  <= 1'b0;
            done <= 1'b0;
            if (b == '0) begin
              dbz  <= 1'b1;
              done <= 1'b1;
              val  <= '0;
            end else if (a == MOST_NEG || b == MOST_NEG) begin
              ovf  <= 1'b1;
              done <= 1'b1;
              val  <= '0;
            end else begin
              busy    <= 1'b1;
              dvd     <= {mag(a), {FBITS{1'b0}}};
              dsr     <= mag(b);
              rem     <= '0;
              quo     <= '0;
              cnt     <= '0;
              neg     <= a[WIDTH-1] ^ b[WIDTH-1];
              ovf_acc <= 1'b0;
              st      <= D_CALC;
            end
          end
        end
        D_CALC: begin
          rem <= rem_nxt;
          dvd <= {dvd[ITER-2:0], 1'b0};
          quo <= {quo[WIDTH-3:0], ge};
          cnt <= cnt + CW'(1);
          // The first FBITS quotient bits lie above the representable range.
          if (ge && cnt < CW'(FBITS)) ovf_acc <= 1'b1;
          if (cnt == CW'(WIDTH-1) && ovf_acc) begin
            ovf  <= 1'b1;
            done <= 1'b1;
            busy <= 1'b0;
            val  <= '0;
            st   <= D_IDLE;
          end else if (cnt == CW'(ITER-1)) begin
            st <= D_SIGN;
          end
        end
        D_SIGN: begin
          val <= neg ? (WIDTH'(0) - {1'b0, quo}) : {1'b0, quo};
          st  <= D_FIN;
        end
        D_FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
          st   <= D_IDLE;
        end
        default: st <= D_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one div instance between NREQ requesters
module div_arbiter
  import math_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int FBITS = DEF_FBITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]      resp_val,
  output logic                  resp_dbz,
  output logic                  resp_ovf,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);

  arb_state_t       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             start;

  logic             pick_hit;
  logic [PW-1:0]    pick_idx;

  logic             div_busy;
  logic             div_done;
  logic             div_dbz;
  logic             div_ovf;
  logic [WIDTH-1:0] div_val;

  // First valid requester at or after p, wrapping; MSB flags that one was found.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] v, input logic [PW-1:0] p);
    logic [PW:0] r;
    int          idx;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NREQ;
      if (v[idx]) r = {1'b1, PW'(idx)};
    end
    return r;
  endfunction

  // Grant is offered only while idle, to the round-robin winner.
  always_comb begin
    {pick_hit, pick_idx} = rr_pick(req_valid, ptr);
    req_ready = '0;
    if (state == IDLE && pick_hit) req_ready[pick_idx] = 1'b1;
  end

  // Sequencer: accept, pulse start, wait for the divider, return one response pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      start      <= 1'b0;
      resp_valid <= '0;
      resp_val   <= '0;
      resp_dbz   <= 1'b0;
      resp_ovf   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      start      <= 1'b0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (|(req_valid & req_ready)) begin
            owner <= pick_idx;
            op_a  <= req_a[int'(pick_idx)*WIDTH +: WIDTH];
            op_b  <= req_b[int'(pick_idx)*WIDTH +: WIDTH];
            ptr   <= (pick_idx == PW'(NREQ-1)) ? '0 : pick_idx + PW'(1);
            start <= 1'b1;
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          // done is sticky, so completion is qualified by the live busy level.
          if (div_done && !div_busy) begin
            resp_val          <= div_val;
            resp_dbz          <= div_dbz;
            resp_ovf          <= div_ovf;
            resp_valid[owner] <= 1'b1;
            state             <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  div #(
    .WIDTH(WIDTH),
    .FBITS(FBITS)
  ) u_div (
    .clk  (clk),
    .rst  (~rst_n),
    .start(start),
    .a    (op_a),
    .b    (op_b),
    .busy (div_busy),
    .done (div_done),
    .dbz  (div_dbz),
    .ovf  (div_ovf),
    .val  (div_val)
  );

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed table-driven bench for div_arbiter
module tb_div_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_val;
  logic         resp_dbz;
  logic         resp_ovf;
  logic         busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] val;
    logic        dbz;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  div_arbiter #(
    .NREQ (4),
    .WIDTH(32),
    .FBITS(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_val  (resp_val),
    .resp_dbz  (resp_dbz),
    .resp_ovf  (resp_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int          n;
    int          edges;
    logic        seen;
    logic [3:0]  onehot;
    onehot = 4'b0001 << v.id;
    req_a[v.id*32 +: 32] = v.a;
    req_b[v.id*32 +: 32] = v.b;
    req_valid = onehot;
    #1;
    n = 0;
    while (!req_ready[v.id] && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({nm, " ready"}, 64'(req_ready), 64'(onehot));
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    req_valid = '0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (resp_valid != '0) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({nm, " latency"}, 64'(seen ? edges : -1), 64'(v.lat));
    check({nm, " resp_valid"}, 64'(resp_valid), 64'(onehot));
    check({nm, " dbz"}, 64'(resp_dbz), 64'(v.dbz));
    check({nm, " ovf"}, 64'(resp_ovf), 64'(v.ovf));
    if (!v.dbz && !v.ovf) check({nm, " val"}, 64'(resp_val), 64'(v.val));
    @(negedge clk);
    check({nm, " pulse end"}, 64'(resp_valid), 64'(0));
    check({nm, " busy idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int         n;
    int         stray;
    int         order[4];
    logic       seen;
    vec_t       v;

    vecs[0]  = '{1, 32'h0006_0000, 32'h0002_0000, 52, 32'h0003_0000, 1'b0, 1'b0};
    vecs[1]  = '{0, 32'hFFFF_0000, 32'h0004_0000, 52, 32'hFFFF_C000, 1'b0, 1'b0};
    vecs[2]  = '{2, 32'h0001_0000, 32'h0000_0000,  3, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3]  = '{3, 32'h8000_0000, 32'h0001_0000,  3, 32'h0000_0000, 1'b0, 1'b1};
    vecs[4]  = '{0, 32'h0001_0000, 32'h8000_0000,  3, 32'h0000_0000, 1'b0, 1'b1};
    vecs[5]  = '{1, 32'h7FFF_0000, 32'h0000_0001, 35, 32'h0000_0000, 1'b0, 1'b1};
    vecs[6]  = '{2, 32'h4000_0000, 32'h0000_8000, 35, 32'h0000_0000, 1'b0, 1'b1};
    vecs[7]  = '{0, 32'h0001_0000, 32'h0003_0000, 52, 32'h0000_5555, 1'b0, 1'b0};
    vecs[8]  = '{2, 32'hFFFF_0000, 32'h0003_0000, 52, 32'hFFFF_AAAB, 1'b0, 1'b0};
    vecs[9]  = '{3, 32'h0007_0000, 32'hFFFE_0000, 52, 32'hFFFC_8000, 1'b0, 1'b0};
    vecs[10] = '{1, 32'h0000_0000, 32'h0005_0000, 52, 32'h0000_0000, 1'b0, 1'b0};
    vecs[11] = '{3, 32'h4000_0000, 32'h0002_0000, 52, 32'h2000_0000, 1'b0, 1'b0};

    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset resp_valid", 64'(resp_valid), 64'(0));
    check("reset resp_val", 64'(resp_val), 64'(0));
    check("reset dbz", 64'(resp_dbz), 64'(0));
    check("reset ovf", 64'(resp_ovf), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset ready", 64'(req_ready), 64'(0));

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort a division with reset 20 edges after accept.
    req_a[32 +: 32] = 32'h0006_0000;
    req_b[32 +: 32] = 32'h0002_0000;
    req_valid = 4'b0010;
    #1;
    check("midrst ready", 64'(req_ready), 64'(4'b0010));
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst resp_valid", 64'(resp_valid), 64'(0));
    check("midrst resp_val", 64'(resp_val), 64'(0));
    check("midrst dbz", 64'(resp_dbz), 64'(0));
    check("midrst ovf", 64'(resp_ovf), 64'(0));
    check("midrst busy", 64'(busy), 64'(0));
    stray = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (resp_valid != '0) stray++;
    end
    check("midrst no response", 64'(stray), 64'(0));
    v = '{1, 32'h0006_0000, 32'h0002_0000, 52, 32'h0003_0000, 1'b0, 1'b0};
    run_vec(v, "after reset");

    // Round-robin: 0, 2 and 3 held together from a fresh pointer.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_b = '0;
    order[0] = 0;
    order[1] = 2;
    order[2] = 3;
    order[3] = 0;
    req_valid = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      for (n = 0; n < 20; n++) begin
        @(negedge clk);
        if (resp_valid != '0) begin
          seen = 1'b1;
          break;
        end
      end
      if (k == 3) req_valid = '0;
      check($sformatf("rr order %0d", k), 64'(seen ? resp_valid : 4'hF), 64'(4'b0001 << order[k]));
      check($sformatf("rr dbz %0d", k), 64'(resp_dbz), 64'(1));
    end
    @(negedge clk);
    check("rr drained busy", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares one fixed-point `div` instance between `NREQ` requesters, for example the per-ray normalisation and projection stages. It accepts one operand pair at a time through a valid/ready handshake and drives the divider's start/reset. It waits for completion, then returns quotient and status flags to the winning requester with a one-cycle response pulse.

## Interface
- `NREQ`, 4: number of requesters (≥2).
- `WIDTH`, 32: operand/result width, signed two's complement.
- `FBITS`, 16: fractional bits (Q16.16 by default).
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NREQ  requester i has an operand pair pending.
- `req_a`  in  NREQ×WIDTH  per-requester dividend.
- `req_b`  in  NREQ×WIDTH  per-requester divisor.
- `req_ready`  out  NREQ  one-hot accept; at most one bit high.
- `resp_valid`  out  NREQ  one-hot, one-cycle pulse to the requester whose division finished.
- `resp_val`  out  WIDTH  quotient; meaningful only when neither flag is set.
- `resp_dbz`  out  1  divide by zero.
- `resp_ovf`  out  1  overflow: SMALLEST operand or integer overflow.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE.** Round-robin pick: the first i with `req_valid[i]`, searching from pointer `ptr` upward and wrapping. `req_ready[winner]` is combinational and high only in IDLE.
  - Accept = `req_valid[i] & req_ready[i]` at an edge.
  - On accept: register a, b and the owner id; set `ptr <= owner+1` (mod NREQ); go to ISSUE.
- **ISSUE.** `start=1` for exactly one cycle, with the registered operands on the divider inputs. Then go to WAIT.
- **WAIT.** Complete when the divider's `busy==0`. The first WAIT cycle already sees the divider's post-start `busy`. Do not edge-detect `done`: it is sticky across operations.
  - On completion, register `val`, `dbz` and `ovf` into `resp_*` and go to RESP.
- **RESP.** Hold `resp_valid[owner]=1` for one cycle, then return to IDLE. No new accept happens in RESP.
- `resp_val`, `resp_dbz` and `resp_ovf` hold their value until the next RESP.
- Divider reset input = `~rst_n`.
- No arithmetic is done in this block. Widths pass straight through to the divider.

## Timing
- Reset (`rst_n=0` at an edge):
  - state=IDLE, `ptr=0`;
  - `resp_valid=0`, `resp_val=0`, `resp_dbz=0`, `resp_ovf=0`, `busy=0`;
  - `req_ready` follows the IDLE pick on the next cycle.
- Normal division, with ITER = WIDTH−1+FBITS (47 by default): `resp_valid` is high in the cycle following the (ITER+5)th edge after the accepting edge, i.e. 52 edges.
- Divide by zero or SMALLEST operand: `resp_valid` follows the 3rd edge after accept.
- Mid-CALC overflow: `resp_valid` follows the (WIDTH+3)rd edge after accept, with `resp_ovf=1`.
- Throughput: one division per latency+1 cycles. The bus is idle for one IDLE cycle between operations when a request is already waiting.
- Simultaneous `req_valid`: exactly one accepted per IDLE cycle. The others wait, holding operands stable until their own `req_ready`.
- `req_valid` dropped before accept: no effect, and `ptr` is unchanged.
- Reset mid-operation: the division is aborted and no `resp_valid` is issued. The requester must re-issue.

## Structure
- Package `math_pkg`:
  - `WIDTH`/`FBITS` defaults;
  - `SMALLEST` constant;
  - `arb_state_t` enum {IDLE, ISSUE, WAIT, RESP}.
- One sub-module: the existing `div`, instantiated once.
- Round-robin selection is a local function `rr_pick(req_valid, ptr)`, not a separate module.

## Test plan
- **Single request.** Requester 1 sends a=0x00060000 (6.0), b=0x00020000 (2.0). Expect `resp_valid[1]` 52 edges after accept, `resp_val=0x00030000`, both flags 0.
- **Negative quotient.** a=0xFFFF0000 (−1.0), b=0x00040000 → `resp_val=0xFFFFC000`.
- **Error flags.**
  - b=0 → `resp_dbz=1`, `resp_ovf=0`, response 3 edges after accept.
  - a=0x80000000 → `resp_ovf=1`.
- **Round-robin fairness.** Requesters 0, 2 and 3 assert together and hold continuously. Expect accept order 0, 2, 3, then 0 again, with each `resp_valid` landing on the matching bit.
- **Reset mid-operation.** Accept a request, pull `rst_n` low for 1 cycle 20 edges later. Expect no `resp_valid`, all outputs 0, `busy=0`. Then a new request completes normally with the correct quotient.
